access_door_controller: RTL



---
 rtl/access_door_controller.sv | 99 +++++++++
 1 files changed

// File: rtl/access_door_controller.sv
// access_door_controller: keypad handshake, comparator sequencing, timed door unlock,
// failed-attempt lockout with intruder alarm, and emergency force-open.
module access_door_controller #(
  parameter int CODE_W      = 12,
  parameter int OPEN_CYCLES = 8,
  parameter int DENY_CYCLES = 2,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  output logic              code_ready,
  output logic [CODE_W-1:0] cmp_code,
  input  logic              cmp_match,
  input  logic              emergency,
  output logic              door_unlock,
  output logic              intruder_alarm,
  output logic              lockout,
  output logic [2:0]        fail_cnt,
  output logic [2:0]        state
);
  localparam int MAX_T = (OPEN_CYCLES > DENY_CYCLES ?
                          (OPEN_CYCLES > LOCK_CYCLES ? OPEN_CYCLES : LOCK_CYCLES) :
                          (DENY_CYCLES > LOCK_CYCLES ? DENY_CYCLES : LOCK_CYCLES));
  localparam int TW = $clog2(MAX_T) + 1;
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CHECK   = 3'd1,
    OPEN    = 3'd2,
    DENY    = 3'd3,
    LOCKOUT = 3'd4,
    EMERG   = 3'd5
  } state_t;
  state_t            r_state, w_state_nx;
  logic [TW-1:0]     r_timer, w_timer_nx;
  logic [2:0]        r_fail, w_fail_nx, w_fail_inc;
  logic [CODE_W-1:0] r_code;
  logic              w_xfer;
  assign code_ready     = (r_state == IDLE);
  assign door_unlock    = (r_state == OPEN) || (r_state == EMERG);
  assign lockout        = (r_state == LOCKOUT);
  assign intruder_alarm = (r_state == LOCKOUT);
  assign cmp_code       = r_code;
  assign fail_cnt       = r_fail;
  assign state          = r_state;
  assign w_xfer         = code_valid && code_ready;
  assign w_fail_inc     = r_fail + 3'd1;
  always_comb begin
    w_state_nx = r_state;
    w_timer_nx = r_timer;
    w_fail_nx  = r_fail;
    if (emergency) begin
      w_state_nx = EMERG;
      w_timer_nx = '0;
      w_fail_nx  = '0;
    end else begin
      case (r_state)
        IDLE: w_state_nx = w_xfer ? CHECK : IDLE;
        CHECK: begin
          if (cmp_match) begin
            w_state_nx = OPEN;
            w_timer_nx = TW'(OPEN_CYCLES - 1);
            w_fail_nx  = '0;
          end else begin
            w_fail_nx  = w_fail_inc;
            w_state_nx = (w_fail_inc == 3'(MAX_FAIL)) ? LOCKOUT : DENY;
            w_timer_nx = (w_fail_inc == 3'(MAX_FAIL)) ? TW'(LOCK_CYCLES - 1) : TW'(DENY_CYCLES - 1);
          end
        end
        OPEN, DENY: begin
          w_state_nx = (r_timer == '0) ? IDLE : r_state;
          w_timer_nx = (r_timer == '0) ? r_timer : r_timer - TW'(1);
        end
        LOCKOUT: begin
          w_state_nx = (r_timer == '0) ? IDLE : LOCKOUT;
          w_timer_nx = (r_timer == '0) ? r_timer : r_timer - TW'(1);
          w_fail_nx  = (r_timer == '0) ? 3'd0 : r_fail;
        end
        // EMERG exits on the first quiet edge; unused encodings recover here too
        default: w_state_nx = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_timer <= '0;
      r_fail  <= '0;
      r_code  <= '0;
    end else begin
      r_state <= w_state_nx;
      r_timer <= w_timer_nx;
      r_fail  <= w_fail_nx;
      if (w_xfer) r_code <= code_in;
    end
  end
endmodule
